// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// Drains words from an upstream FIFO (pop/empty/registered data_out) and
// shifts each one out on an asynchronous serial line:
//   start bit (0), N_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Every output is a flop whose next value is decoded from the next state, so
// the outputs are glitch-free and never depend combinationally on inputs.

module fifo_serial_tx #(
   parameter int N_BITS       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [N_BITS-1:0] fifo_data,
   output logic              fifo_pop,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   // Elaboration-time sanity checks on the configuration.
   if (N_BITS < 1) begin : g_bad_n_bits
      $error("fifo_serial_tx: N_BITS must be >= 1");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("fifo_serial_tx: CLKS_PER_BIT must be >= 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("fifo_serial_tx: STOP_BITS must be 1 or 2");
   end

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(N_BITS + 1);

   // Last baud tick of a bit, last data bit index, last stop bit index.
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(N_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [N_BITS-1:0]   shift_q, shift_d;
   logic                parity_q, parity_d;

   logic                tx_q, tx_d;
   logic                pop_q, pop_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                bit_end;

   // FIFO handshake: a pop pulse is a request that the FIFO always honours
   // (it is issued only after seeing !fifo_empty in IDLE); the popped word is
   // presented on fifo_data in the following cycle, which is the LOAD cycle,
   // and is sampled only there. fifo_empty is consulted only in IDLE.

   // Next-state logic: frame sequencing, baud/bit counting, shift and parity.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      bit_end  = (baud_q == BAUD_LAST);

      case (state_q)
         S_IDLE: begin
            if (enable && !fifo_empty) begin
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            state_d = S_LOAD;
         end

         S_LOAD: begin
            shift_d  = fifo_data;
            parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
            baud_d   = '0;
            bit_d    = '0;
            state_d  = S_START;
         end

         S_START: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_STOP: begin
            // bit_q is reused to count stop bits.
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   // Output decode from the next state, so the registered outputs line up
   // exactly with the state they describe.
   always_comb begin
      tx_d   = 1'b1;
      pop_d  = (state_d == S_FETCH);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         pop_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         pop_q    <= pop_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx         = tx_q;
   assign fifo_pop   = pop_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Testbench for fifo_serial_tx.
// Three instances share one FIFO model; only the selected one is enabled and
// sees a non-empty FIFO:
//   0: no parity, 1 stop    1: even parity, 2 stop    2: odd parity, 1 stop
// Words are pushed on exp_q when loaded; the monitor pops one at each frame
// start and checks the line cycle by cycle against a frame built from the word.

module tb_fifo_serial_tx;

   localparam int CPB = 4;
   localparam int NB  = 8;
   localparam logic [2:0] P_EN    = 3'b110;
   localparam logic [2:0] P_ODD   = 3'b100;
   localparam logic [2:0] P_STOP2 = 3'b010;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   int            sel = 0;
   logic [NB-1:0] fifo_data = '0;
   logic          f_empty = 1'b1;
   logic [2:0]    en_v, empty_v, pop_v, tx_v, busy_v, done_v;

   logic [NB-1:0] fifo_q[$];
   logic [NB-1:0] exp_q[$];

   int errors   = 0;
   int checks   = 0;
   int pop_cnt  = 0;
   int done_cnt = 0;

   // clock / reset
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign en_v[g]    = (sel == g) ? en : 1'b0;
      assign empty_v[g] = (sel == g) ? f_empty : 1'b1;
      fifo_serial_tx #(
         .N_BITS      (NB),
         .CLKS_PER_BIT(CPB),
         .PARITY_EN   (P_EN[g] ? 1 : 0),
         .PARITY_ODD  (P_ODD[g] ? 1 : 0),
         .STOP_BITS   (P_STOP2[g] ? 2 : 1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .enable    (en_v[g]),
         .fifo_empty(empty_v[g]),
         .fifo_data (fifo_data),
         .fifo_pop  (pop_v[g]),
         .tx        (tx_v[g]),
         .busy      (busy_v[g]),
         .frame_done(done_v[g])
      );
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", name, act, req, $time, sel);
      end
   endfunction

   // Number of serial bits in a frame for a configuration.
   function automatic int frame_bits(input int s);
      return 1 + NB + (P_EN[s] ? 1 : 0) + (P_STOP2[s] ? 2 : 1);
   endfunction

   // Line level of every serial bit of the frame carrying w (idle-high padding).
   function automatic logic [11:0] frame_levels(input logic [NB-1:0] w, input int s);
      logic [11:0] v;
      v    = '1;
      v[0] = 1'b0;
      for (int i = 0; i < NB; i++) v[1 + i] = w[i];
      if (P_EN[s]) v[1 + NB] = (^w) ^ P_ODD[s];
      return v;
   endfunction

   // FIFO model: registered data_out, garbage whenever no pop was issued.
   always @(posedge clk) begin
      if (pop_v[sel]) begin
         pop_cnt <= pop_cnt + 1;
         if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
         else fifo_data <= NB'($urandom);
      end else begin
         fifo_data <= NB'($urandom);
      end
   end

   // Monitor: pos = cycles since FETCH (-1 when idle); frame starts at pos 2.
   int            pos = -1;
   logic          go  = 1'b0;
   logic          cur_idle;
   logic [11:0]   lv = '1;
   int            flen = 0;
   logic [NB-1:0] cur_w = '0;
   logic [NB-1:0] rx = '0;
   logic          e_tx, e_done;
   int            bidx;

   always @(negedge clk) begin
      f_empty = (fifo_q.size() == 0);
      if (pos == -1 && go) pos = 0;
      cur_idle = (pos == -1);
      e_tx     = 1'b1;
      e_done   = 1'b0;
      if (pos == 2) begin
         if (exp_q.size() == 0) begin
            chk("exp_q_underflow", 32'd0, 32'd1);
            cur_w = 'x;
         end else begin
            cur_w = exp_q.pop_front();
         end
         lv   = frame_levels(cur_w, sel);
         flen = CPB * frame_bits(sel);
      end
      if (pos >= 2) begin
         e_tx   = lv[(pos - 2) / CPB];
         e_done = (pos == flen + 1);
      end
      chk("fifo_pop", 32'(pop_v[sel]), 32'(pos == 0));
      chk("busy", 32'(busy_v[sel]), 32'(pos >= 0));
      chk("tx", 32'(tx_v[sel]), 32'(e_tx));
      chk("frame_done", 32'(done_v[sel]), 32'(e_done));
      if (done_v[sel]) done_cnt++;
      if (pos >= 2) begin
         bidx = (pos - 2) / CPB;
         if (((pos - 2) % CPB) == CPB / 2 && bidx >= 1 && bidx <= NB) rx[bidx - 1] = tx_v[sel];
         if (pos == flen + 1) chk("word", 32'(rx), 32'(cur_w));
      end
      if (rst) begin
         // A word popped but not yet on the line is lost by the reset.
         if ((pos == 0 || pos == 1) && exp_q.size() > 0) void'(exp_q.pop_front());
         pos = -1;
      end else if (pos >= 2 && pos == flen + 1) begin
         pos = -1;
      end else if (pos >= 0) begin
         pos++;
      end
      go = cur_idle && en && !f_empty && !rst;
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [NB-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic wait_quiet(input string tag);
      int q = 0;
      int n = 0;
      while (q < 4 && n < 1500) begin
         tick(1);
         n++;
         if (!busy_v[sel] && (f_empty || !en)) q++;
         else q = 0;
      end
      chk({tag, "_quiet"}, 32'(q >= 4), 32'd1);
   endtask

   task automatic wait_pop(input string tag);
      int n = 0;
      while (!pop_v[sel] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_pop_seen"}, 32'(pop_v[sel]), 32'd1);
   endtask

   // stimulus
   initial begin : main
      int n;
      int p0;
      int d0;
      logic [NB-1:0] w;

      // reset held 3 cycles with a word waiting and enable high
      rst = 1'b1;
      en  = 1'b1;
      sel = 0;
      load(8'hA5);
      tick(3);
      rst = 1'b0;
      d0  = done_cnt;
      n   = 0;
      while (!pop_v[0] && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("first_pop_delay", 32'(n), 32'd2);

      // single word 0xA5, no parity, 1 stop
      wait_quiet("t2");
      chk("t2_frames", 32'(done_cnt - d0), 32'd1);
      chk("t2_pops", 32'(pop_cnt), 32'd1);

      // parity: even (2 stop) then odd (1 stop) on word 0x07
      sel = 1;
      load(8'h07);
      wait_quiet("t3_even");
      sel = 2;
      load(8'h07);
      wait_quiet("t3_odd");

      // three back-to-back words
      sel = 0;
      p0  = pop_cnt;
      load(8'h11);
      load(8'h22);
      load(8'h33);
      wait_quiet("t4");
      chk("t4_pops", 32'(pop_cnt - p0), 32'd3);
      tick(20);
      chk("t4_no_extra_pop", 32'(pop_cnt - p0), 32'd3);

      // enable dropped during data bit 3 with two words queued
      p0 = pop_cnt;
      d0 = done_cnt;
      load(8'h3C);
      load(8'hC3);
      wait_pop("t5");
      tick(18);
      en = 1'b0;
      n  = 0;
      while (!done_v[sel] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t5_done_seen", 32'(done_v[sel]), 32'd1);
      tick(20);
      chk("t5_pops_while_disabled", 32'(pop_cnt - p0), 32'd1);
      chk("t5_frames_while_disabled", 32'(done_cnt - d0), 32'd1);
      en = 1'b1;
      wait_quiet("t5");
      chk("t5_pops", 32'(pop_cnt - p0), 32'd2);

      // reset during data bit 5, two stop bits
      sel = 1;
      p0  = pop_cnt;
      d0  = done_cnt;
      load(8'h5A);
      load(8'h96);
      wait_pop("t6");
      tick(27);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t6_no_done_after_rst", 32'(done_cnt - d0), 32'd0);
      wait_quiet("t6");
      chk("t6_pops", 32'(pop_cnt - p0), 32'd2);
      chk("t6_frames", 32'(done_cnt - d0), 32'd1);

      // randomized bursts with enable wobble
      for (int b = 0; b < 8; b++) begin
         sel = $urandom_range(0, 2);
         en  = 1'b1;
         for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            w = NB'($urandom);
            load(w);
            tick($urandom_range(0, 30));
            if ($urandom_range(0, 3) == 0) begin
               en = 1'b0;
               tick($urandom_range(1, 40));
               en = 1'b1;
            end
         end
         wait_quiet("rand");
      end

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("fifo_drained", 32'(fifo_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Consumer end of the FIFO. Drains N_BITS-wide words through the FIFO's pop/empty/data_out interface and serializes each word onto a single asynchronous-serial line.
- Frame format: start bit, data LSB first, optional parity, one or two stop bits.
- Sits between a transmit FIFO and the pad/link.
- The FIFO's data_out is registered, so the word is valid one cycle after pop.

Parameters:
N_BITS, 8, data bits per frame; must be >= 1
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
enable  input  1  permits starting new frames
fifo_empty  input  1  empty flag from the upstream FIFO
fifo_data  input  N_BITS  upstream FIFO data_out; valid the cycle after fifo_pop
fifo_pop  output  1  pop request to the FIFO; one-cycle pulse per word
tx  output  1  serial line; idle high
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Parameter checks at elaboration: $error if N_BITS < 1, CLKS_PER_BIT < 2, or STOP_BITS not in {1, 2}.
- Reset (sampled on posedge when rst = 1; overrides everything):
  - state = IDLE; tx = 1; fifo_pop = 0; busy = 0; frame_done = 0.
  - Bit counter, baud counter, shift register and parity register cleared.
- All outputs are registered or Moore-decoded from state; none depends combinationally on inputs.
- States:
  - IDLE: tx = 1. If enable && !fifo_empty, next = FETCH; else stay.
  - FETCH (1 cycle): fifo_pop = 1. Next = LOAD.
  - LOAD (1 cycle): capture fifo_data into the shift register; compute parity (XOR of data, inverted when PARITY_ODD = 1); tx = 1. Next = START.
  - START: tx = 0 for CLKS_PER_BIT cycles. Next = DATA.
  - DATA: N_BITS bits, each held CLKS_PER_BIT cycles, LSB first; shift right at each bit boundary. Next = PARITY if PARITY_EN, else STOP.
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles. Next = STOP.
  - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done = 1 on the final cycle. Next = IDLE.
- Timing:
  - Baud counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Bit counter width $clog2(N_BITS+1).
  - Frame length on the line = CLKS_PER_BIT*(1 + N_BITS + PARITY_EN + STOP_BITS) cycles.
  - Back-to-back words: 3 extra idle-high cycles (IDLE, FETCH, LOAD) between the end of a stop bit and the next start bit.
  - Latency: IDLE-with-word to first start-bit cycle = 3 cycles.
- Boundary conditions:
  - enable deasserted mid-frame: the current frame completes unchanged; no new FETCH.
  - fifo_empty rising during a frame: no effect; it is checked only in IDLE.
  - Exactly one fifo_pop pulse per transmitted word. fifo_pop is never asserted while fifo_empty was 1 in the deciding IDLE cycle.
  - fifo_data changes outside LOAD: ignored.
  - Reset mid-frame: tx = 1 on the next cycle; no frame_done. The popped word is dropped; there is no re-pop.

Test Plan:
1. Assert rst for 3 cycles with the FIFO non-empty and enable = 1 -> tx = 1, fifo_pop = 0, busy = 0 throughout. First pop occurs 2 cycles after rst falls (IDLE, then FETCH).
2. N_BITS = 8, CLKS_PER_BIT = 4, no parity, 1 stop; one word 0xA5 -> fifo_pop is a single pulse. tx sequence, each level held 4 cycles: 0, 1, 0, 1, 0, 0, 1, 0, 1, 1. frame_done pulses on cycle 40 after start-bit onset; busy then drops.
3. PARITY_EN = 1; word 0x07 -> parity bit = 1 with PARITY_ODD = 0 and 0 with PARITY_ODD = 1. Frame = 44 cycles at CLKS_PER_BIT = 4.
4. FIFO preloaded with 0x11, 0x22, 0x33; enable held high -> exactly 3 fifo_pop pulses. Each inter-frame gap is 3 tx-high cycles. Words appear in order. Then IDLE with tx = 1 and no further pops.
5. enable dropped during bit 3 of the first word, FIFO holding 2 words -> the first frame completes with frame_done; no second fifo_pop while enable = 0. Re-asserting enable starts the second frame 3 cycles later.
6. STOP_BITS = 2, CLKS_PER_BIT = 4: rst pulsed during data bit 5 -> tx = 1 the next cycle, no frame_done. After release, the next word is fetched fresh. The stop phase of that frame is 8 high cycles.
